// File: rtl/multi_rename_unit_pkg.sv
// Shared widths, lane-count defaults and lane-vector types for the multi-lane
// register rename unit and its free-list allocator.
`ifndef ARCH_REG_NUM_WIDTH
`define ARCH_REG_NUM_WIDTH 5
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif

package multi_rename_unit_pkg;
  localparam int ARCH_REG_W           = `ARCH_REG_NUM_WIDTH;
  localparam int PHYS_REG_W           = `PHYSICAL_REG_NUM_WIDTH;
  localparam int RENAME_WIDTH_DEFAULT = 2;
  localparam int COMMIT_WIDTH_DEFAULT = 2;

  typedef logic [ARCH_REG_W-1:0] arch_reg_t;
  typedef logic [PHYS_REG_W-1:0] phys_reg_t;

  typedef arch_reg_t [RENAME_WIDTH_DEFAULT-1:0] rn_arch_vec_t;
  typedef phys_reg_t [RENAME_WIDTH_DEFAULT-1:0] rn_phys_vec_t;
  typedef arch_reg_t [COMMIT_WIDTH_DEFAULT-1:0] cm_arch_vec_t;
  typedef phys_reg_t [COMMIT_WIDTH_DEFAULT-1:0] cm_phys_vec_t;
endpackage

// File: rtl/free_list_alloc.sv
// Free physical-register bitmask with an N-lane lowest-first picker and a
// popcount of the registered mask.
module free_list_alloc
  import multi_rename_unit_pkg::*;
#(
  parameter int PHYS_W     = PHYS_REG_W,
  parameter int LANES      = RENAME_WIDTH_DEFAULT,
  parameter int RESET_USED = 1 << ARCH_REG_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LANES-1:0]             alloc_req,
  input  logic                         alloc_fire,
  input  logic [(1<<PHYS_W)-1:0]       release_mask,
  input  logic                         flush,
  input  logic [(1<<PHYS_W)-1:0]       flush_free_mask,
  output logic [LANES-1:0][PHYS_W-1:0] alloc_phys,
  output logic                         can_alloc,
  output logic [PHYS_W:0]              free_count
);
  localparam int P = 1 << PHYS_W;

  logic [P-1:0]  free_q, free_d;
  logic [P-1:0]  avail, taken;
  logic [PHYS_W:0] req_count;
  logic          found;

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    avail      = free_q;
    taken      = '0;
    req_count  = '0;
    alloc_phys = '0;
    found      = 1'b0;
    // NOTE: blocking updates of avail let each later lane see what earlier
    // lanes already took within the same evaluation.
    for (int l = 0; l < LANES; l++) begin
      if (alloc_req[l]) begin
        req_count = req_count + (PHYS_W+1)'(1);
        found     = 1'b0;
        for (int p = 0; p < P; p++) begin
          if (!found && avail[p]) begin
            alloc_phys[l] = PHYS_W'(p);
            avail[p]      = 1'b0;
            taken[p]      = 1'b1;
            found         = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    free_count = '0;
    for (int p = 0; p < P; p++) free_count = free_count + (PHYS_W+1)'(free_q[p]);
  end

  assign can_alloc = free_count >= req_count;

  // Commit releases land in the mask only, so they are pickable next cycle.
  always_comb begin
    if (flush) free_d = flush_free_mask;
    else       free_d = (alloc_fire ? (free_q & ~taken) : free_q) | release_mask;
  end

  // NOTE: state flops use non-blocking assignment so all flops sample
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < P; p++) free_q[p] <= (p >= RESET_USED);
    end else begin
      free_q <= free_d;
    end
  end
endmodule

// File: rtl/multi_rename_unit.sv
// Multi-lane register rename: speculative/committed maps, commit-side
// in-use tracking, intra-group bypass and flush recovery to committed state.
module multi_rename_unit
  import multi_rename_unit_pkg::*;
#(
  parameter int ARCH_REG_NUM_WIDTH     = `ARCH_REG_NUM_WIDTH,
  parameter int PHYSICAL_REG_NUM_WIDTH = `PHYSICAL_REG_NUM_WIDTH,
  parameter int RENAME_WIDTH           = RENAME_WIDTH_DEFAULT,
  parameter int COMMIT_WIDTH           = COMMIT_WIDTH_DEFAULT
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               rename_valid,
  output logic                                               rename_ready,
  input  logic [RENAME_WIDTH-1:0][ARCH_REG_NUM_WIDTH-1:0]     rn_rs1,
  input  logic [RENAME_WIDTH-1:0][ARCH_REG_NUM_WIDTH-1:0]     rn_rs2,
  input  logic [RENAME_WIDTH-1:0][ARCH_REG_NUM_WIDTH-1:0]     rn_rd,
  input  logic [RENAME_WIDTH-1:0]                            rn_rd_wr,
  output logic [RENAME_WIDTH-1:0][PHYSICAL_REG_NUM_WIDTH-1:0] rn_phy_rs1,
  output logic [RENAME_WIDTH-1:0][PHYSICAL_REG_NUM_WIDTH-1:0] rn_phy_rs2,
  output logic [RENAME_WIDTH-1:0][PHYSICAL_REG_NUM_WIDTH-1:0] rn_phy_rd,
  output logic [RENAME_WIDTH-1:0][PHYSICAL_REG_NUM_WIDTH-1:0] rn_phy_old_rd,
  input  logic [COMMIT_WIDTH-1:0]                            cm_valid,
  input  logic [COMMIT_WIDTH-1:0]                            cm_wr,
  input  logic [COMMIT_WIDTH-1:0][ARCH_REG_NUM_WIDTH-1:0]     cm_arch_rd,
  input  logic [COMMIT_WIDTH-1:0][PHYSICAL_REG_NUM_WIDTH-1:0] cm_phy_rd,
  input  logic [COMMIT_WIDTH-1:0][PHYSICAL_REG_NUM_WIDTH-1:0] cm_phy_old_rd,
  input  logic                                               flush,
  output logic [PHYSICAL_REG_NUM_WIDTH:0]                    free_count
);
  localparam int A  = 1 << ARCH_REG_NUM_WIDTH;
  localparam int P  = 1 << PHYSICAL_REG_NUM_WIDTH;
  localparam int PW = PHYSICAL_REG_NUM_WIDTH;

  logic [PW-1:0] spec_map_q [A];
  logic [PW-1:0] spec_map_d [A];
  logic [PW-1:0] cmt_map_q  [A];
  logic [PW-1:0] cmt_map_d  [A];
  logic [P-1:0]  in_use_q, in_use_d, release_mask, flush_free_mask;

  logic [RENAME_WIDTH-1:0]         alloc_req;
  logic [RENAME_WIDTH-1:0][PW-1:0] alloc_phys;
  logic                            can_alloc, fire;

  always_comb begin
    for (int i = 0; i < RENAME_WIDTH; i++) alloc_req[i] = rn_rd_wr[i] && (rn_rd[i] != '0);
  end

  assign rename_ready    = !flush && can_alloc;
  assign fire            = rename_valid && rename_ready;
  assign flush_free_mask = ~in_use_d;

  free_list_alloc #(
    .PHYS_W     (PW),
    .LANES      (RENAME_WIDTH),
    .RESET_USED (A)
  ) u_free_list (
    .clk             (clk),
    .reset           (reset),
    .alloc_req       (alloc_req),
    .alloc_fire      (fire),
    .release_mask    (release_mask),
    .flush           (flush),
    .flush_free_mask (flush_free_mask),
    .alloc_phys      (alloc_phys),
    .can_alloc       (can_alloc),
    .free_count      (free_count)
  );

  // Sources and old-rd read the map, then the newest earlier allocating lane overrides.
  always_comb begin
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      rn_phy_rs1[i]    = spec_map_q[rn_rs1[i]];
      rn_phy_rs2[i]    = spec_map_q[rn_rs2[i]];
      rn_phy_old_rd[i] = spec_map_q[rn_rd[i]];
      for (int j = 0; j < i; j++) begin
        if (alloc_req[j]) begin
          if (rn_rd[j] == rn_rs1[i]) rn_phy_rs1[i]    = alloc_phys[j];
          if (rn_rd[j] == rn_rs2[i]) rn_phy_rs2[i]    = alloc_phys[j];
          if (rn_rd[j] == rn_rd[i])  rn_phy_old_rd[i] = alloc_phys[j];
        end
      end
      rn_phy_rd[i] = alloc_req[i] ? alloc_phys[i] : '0;
      if (!alloc_req[i]) rn_phy_old_rd[i] = '0;
    end
  end

  always_comb begin
    cmt_map_d    = cmt_map_q;
    in_use_d     = in_use_q;
    release_mask = '0;
    for (int c = 0; c < COMMIT_WIDTH; c++) begin
      if (cm_valid[c] && cm_wr[c] && (cm_arch_rd[c] != '0)) begin
        cmt_map_d[cm_arch_rd[c]]      = cm_phy_rd[c];
        in_use_d[cm_phy_rd[c]]        = 1'b1;
        in_use_d[cm_phy_old_rd[c]]    = 1'b0;
        release_mask[cm_phy_old_rd[c]] = 1'b1;
      end
    end

    spec_map_d = spec_map_q;
    if (flush) begin
      spec_map_d = cmt_map_d;
    end else if (fire) begin
      for (int i = 0; i < RENAME_WIDTH; i++) begin
        if (alloc_req[i]) spec_map_d[rn_rd[i]] = alloc_phys[i];
      end
    end
  end

  // NOTE: the maps are flop arrays rather than RAM, so they take an async
  // reset straight to the identity mapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < A; a++) begin
        spec_map_q[a] <= PW'(a);
        cmt_map_q[a]  <= PW'(a);
      end
      for (int p = 0; p < P; p++) in_use_q[p] <= (p < A);
    end else begin
      spec_map_q <= spec_map_d;
      cmt_map_q  <= cmt_map_d;
      in_use_q   <= in_use_d;
    end
  end
endmodule

// File: tb/tb_multi_rename_unit.sv
// Self-checking bench for multi_rename_unit: a behavioural model pushes
// expected outputs into a scoreboard queue which is drained against the DUT.
module tb_multi_rename_unit;
  import multi_rename_unit_pkg::*;

  localparam int AW = ARCH_REG_W;
  localparam int PW = PHYS_REG_W;
  localparam int RW = RENAME_WIDTH_DEFAULT;
  localparam int CW = COMMIT_WIDTH_DEFAULT;
  localparam int A  = 1 << AW;
  localparam int P  = 1 << PW;

  logic clk = 1'b0;
  logic reset;
  logic rename_valid, rename_ready, flush;
  rn_arch_vec_t rn_rs1, rn_rs2, rn_rd;
  logic [RW-1:0] rn_rd_wr;
  rn_phys_vec_t rn_phy_rs1, rn_phy_rs2, rn_phy_rd, rn_phy_old_rd;
  logic [CW-1:0] cm_valid, cm_wr;
  cm_arch_vec_t cm_arch_rd;
  cm_phys_vec_t cm_phy_rd, cm_phy_old_rd;
  logic [PW:0] free_count;

  always #5 clk = ~clk;

  multi_rename_unit #(
    .ARCH_REG_NUM_WIDTH     (AW),
    .PHYSICAL_REG_NUM_WIDTH (PW),
    .RENAME_WIDTH           (RW),
    .COMMIT_WIDTH           (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rename_valid  (rename_valid),
    .rename_ready  (rename_ready),
    .rn_rs1        (rn_rs1),
    .rn_rs2        (rn_rs2),
    .rn_rd         (rn_rd),
    .rn_rd_wr      (rn_rd_wr),
    .rn_phy_rs1    (rn_phy_rs1),
    .rn_phy_rs2    (rn_phy_rs2),
    .rn_phy_rd     (rn_phy_rd),
    .rn_phy_old_rd (rn_phy_old_rd),
    .cm_valid      (cm_valid),
    .cm_wr         (cm_wr),
    .cm_arch_rd    (cm_arch_rd),
    .cm_phy_rd     (cm_phy_rd),
    .cm_phy_old_rd (cm_phy_old_rd),
    .flush         (flush),
    .free_count    (free_count)
  );

  typedef enum {F_READY, F_FCNT, F_RS1, F_RS2, F_RD, F_OLD} field_e;
  typedef struct {
    field_e f;
    int     lane;
    int     exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state
  int m_spec[A];
  int m_cmt[A];
  bit m_free[P];
  bit m_inuse[P];
  int nx_spec[A];
  bit nx_free[P];
  bit nx_fire;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_value(input field_e f, input int lane);
    case (f)
      F_READY: return {31'b0, rename_ready};
      F_FCNT:  return 32'(free_count);
      F_RS1:   return 32'(rn_phy_rs1[lane]);
      F_RS2:   return 32'(rn_phy_rs2[lane]);
      F_RD:    return 32'(rn_phy_rd[lane]);
      default: return 32'(rn_phy_old_rd[lane]);
    endcase
  endfunction

  function automatic int model_fc();
    int n = 0;
    for (int p = 0; p < P; p++) n += int'(m_free[p]);
    return n;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < A; a++) begin
      m_spec[a] = a;
      m_cmt[a]  = a;
    end
    for (int p = 0; p < P; p++) begin
      m_inuse[p] = (p < A);
      m_free[p]  = (p >= A);
    end
  endtask

  task automatic idle();
    rename_valid = 1'b0;
    flush        = 1'b0;
    rn_rs1 = '0; rn_rs2 = '0; rn_rd = '0; rn_rd_wr = '0;
    cm_valid = '0; cm_wr = '0; cm_arch_rd = '0; cm_phy_rd = '0; cm_phy_old_rd = '0;
  endtask

  task automatic set_lane(input int i, input int rs1, input int rs2, input int rd, input bit wr);
    rn_rs1[i]   = arch_reg_t'(rs1);
    rn_rs2[i]   = arch_reg_t'(rs2);
    rn_rd[i]    = arch_reg_t'(rd);
    rn_rd_wr[i] = wr;
  endtask

  task automatic set_commit(input int c, input int arch, input int phy, input int old);
    cm_valid[c]      = 1'b1;
    cm_wr[c]         = 1'b1;
    cm_arch_rd[c]    = arch_reg_t'(arch);
    cm_phy_rd[c]     = phys_reg_t'(phy);
    cm_phy_old_rd[c] = phys_reg_t'(old);
  endtask

  // Settle, predict this cycle's outputs into the scoreboard, then drain it.
  task automatic eval_cycle();
    int fc, nalloc;
    bit rdy, found;
    sb_item_t it;
    #2;
    nx_spec = m_spec;
    nx_free = m_free;
    fc      = model_fc();
    nalloc  = 0;
    for (int i = 0; i < RW; i++) begin
      int e_rd, e_old;
      e_rd  = 0;
      e_old = 0;
      sb_q.push_back('{F_RS1, i, nx_spec[rn_rs1[i]]});
      sb_q.push_back('{F_RS2, i, nx_spec[rn_rs2[i]]});
      if (rn_rd_wr[i] && rn_rd[i] != 0) begin
        nalloc++;
        found = 1'b0;
        for (int p = 0; p < P; p++) begin
          if (!found && nx_free[p]) begin
            e_rd       = p;
            nx_free[p] = 1'b0;
            found      = 1'b1;
          end
        end
        e_old = nx_spec[rn_rd[i]];
        nx_spec[rn_rd[i]] = e_rd;
      end
      sb_q.push_back('{F_RD, i, e_rd});
      sb_q.push_back('{F_OLD, i, e_old});
    end
    // Lane outputs are only meaningful when the free list can cover the group.
    if (fc < nalloc) sb_q.delete();
    rdy     = !flush && (fc >= nalloc);
    nx_fire = rename_valid && rdy;
    sb_q.push_back('{F_READY, 0, int'(rdy)});
    sb_q.push_back('{F_FCNT, 0, fc});
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      check($sformatf("%s[%0d]", it.f.name(), it.lane), dut_value(it.f, it.lane), 32'(it.exp));
    end
  endtask

  task automatic tick();
    bit rel[P];
    @(posedge clk);
    cyc++;
    for (int p = 0; p < P; p++) rel[p] = 1'b0;
    for (int c = 0; c < CW; c++) begin
      if (cm_valid[c] && cm_wr[c] && cm_arch_rd[c] != 0) begin
        m_cmt[cm_arch_rd[c]]     = int'(cm_phy_rd[c]);
        m_inuse[cm_phy_rd[c]]    = 1'b1;
        m_inuse[cm_phy_old_rd[c]] = 1'b0;
        rel[cm_phy_old_rd[c]]    = 1'b1;
      end
    end
    if (flush) begin
      m_spec = m_cmt;
      for (int p = 0; p < P; p++) m_free[p] = !m_inuse[p];
    end else begin
      if (nx_fire) begin
        m_spec = nx_spec;
        m_free = nx_free;
      end
      for (int p = 0; p < P; p++) if (rel[p]) m_free[p] = 1'b1;
    end
    #1;
  endtask

  task automatic step();
    eval_cycle();
    tick();
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic random_group(input int nalloc);
    for (int i = 0; i < RW; i++)
      set_lane(i, $urandom_range(0, A-1), $urandom_range(0, A-1), $urandom_range(1, A-1), i < nalloc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    do_reset();
    check("reset_free_count", 32'(free_count), 32);
    check("reset_ready", {31'b0, rename_ready}, 1);

    // First group after reset takes 32 and 33.
    set_lane(0, 0, 0, 1, 1); set_lane(1, 0, 0, 2, 1); rename_valid = 1'b1;
    eval_cycle();
    check("g1_rd0", 32'(rn_phy_rd[0]), 32);
    check("g1_rd1", 32'(rn_phy_rd[1]), 33);
    check("g1_old0", 32'(rn_phy_old_rd[0]), 1);
    check("g1_old1", 32'(rn_phy_old_rd[1]), 2);
    tick();
    idle();
    check("g1_free_count", 32'(free_count), 30);

    // Intra-group bypass on x5.
    set_lane(0, 3, 4, 5, 1); set_lane(1, 5, 0, 5, 1); rename_valid = 1'b1;
    eval_cycle();
    check("byp_rd0", 32'(rn_phy_rd[0]), 34);
    check("byp_rs1_l1", 32'(rn_phy_rs1[1]), 34);
    check("byp_old_l1", 32'(rn_phy_old_rd[1]), 34);
    check("byp_rd1", 32'(rn_phy_rd[1]), 35);
    tick();
    idle();
    set_lane(0, 5, 0, 0, 0);
    eval_cycle();
    check("map_x5", 32'(rn_phy_rs1[0]), 35);
    tick();

    // x0 destination never allocates.
    set_lane(0, 0, 0, 0, 1); set_lane(1, 0, 0, 0, 0); rename_valid = 1'b1;
    eval_cycle();
    check("x0_rd", 32'(rn_phy_rd[0]), 0);
    check("x0_old", 32'(rn_phy_old_rd[0]), 0);
    tick();
    check("x0_free_count", 32'(free_count), 28);

    // Drain the free list down to one register.
    while (model_fc() > 1) begin
      random_group(model_fc() >= 3 ? 2 : 1);
      rename_valid = 1'b1;
      step();
    end
    random_group(2); rename_valid = 1'b1;
    eval_cycle();
    check("short_ready", {31'b0, rename_ready}, 0);
    tick();
    check("short_free_count", 32'(free_count), 1);
    random_group(1);
    eval_cycle();
    check("last_ready", {31'b0, rename_ready}, 1);
    check("last_rd0", 32'(rn_phy_rd[0]), 63);
    tick();
    check("empty_free_count", 32'(free_count), 0);

    // Commit frees phys 1; it is pickable only from the next cycle.
    idle();
    set_commit(0, 1, 32, 1);
    set_lane(0, 0, 0, 7, 1); rename_valid = 1'b1;
    eval_cycle();
    check("commit_cycle_ready", {31'b0, rename_ready}, 0);
    tick();
    idle();
    set_lane(0, 0, 0, 7, 1); rename_valid = 1'b1;
    eval_cycle();
    check("freed_count", 32'(free_count), 1);
    check("freed_pick", 32'(rn_phy_rd[0]), 1);
    tick();
    check("refill_count", 32'(free_count), 0);

    // Flush with a same-cycle commit: committed state wins.
    idle();
    set_commit(0, 2, 33, 2);
    flush = 1'b1;
    set_lane(0, 0, 0, 9, 1); rename_valid = 1'b1;
    eval_cycle();
    check("flush_ready", {31'b0, rename_ready}, 0);
    tick();
    idle();
    check("flush_free_count", 32'(free_count), 32);
    set_lane(0, 1, 2, 0, 0); set_lane(1, 5, 0, 0, 0);
    eval_cycle();
    check("flush_x1", 32'(rn_phy_rs1[0]), 32);
    check("flush_x2", 32'(rn_phy_rs2[0]), 33);
    check("flush_x5", 32'(rn_phy_rs1[1]), 5);
    tick();

    // Same rd in both lanes, then both commits to x3 in one cycle.
    set_lane(0, 0, 0, 3, 1); set_lane(1, 0, 0, 3, 1); rename_valid = 1'b1;
    step();
    idle();
    set_commit(0, 3, 1, 3); set_commit(1, 3, 2, 1);
    step();
    idle();
    flush = 1'b1;
    step();
    idle();
    set_lane(0, 3, 0, 0, 0);
    eval_cycle();
    check("commit_x3_high_lane", 32'(rn_phy_rs1[0]), 2);
    tick();

    // Random renames with occasional flushes.
    for (int n = 0; n < 60; n++) begin
      idle();
      for (int i = 0; i < RW; i++)
        set_lane(i, $urandom_range(0, A-1), $urandom_range(0, A-1), $urandom_range(0, A-1), 1'($urandom_range(0, 1)));
      rename_valid = 1'($urandom_range(0, 3) != 0);
      flush        = 1'($urandom_range(0, 9) == 0);
      step();
    end

    // Reset asserted mid-group overrides everything.
    idle();
    set_lane(0, 0, 0, 1, 1); rename_valid = 1'b1; flush = 1'b1;
    set_commit(0, 4, 40, 4);
    reset = 1'b1;
    #1;
    model_reset();
    check("midreset_free_count", 32'(free_count), 32);
    check("midreset_rd0", 32'(rn_phy_rd[0]), 32);
    @(posedge clk);
    #1;
    idle();
    reset = 1'b0;
    step();

    // Ten speculative renames then flush restore identity.
    do_reset();
    for (int g = 0; g < 5; g++) begin
      random_group(2); rename_valid = 1'b1;
      step();
    end
    idle();
    check("spec_free_count", 32'(free_count), 22);
    flush = 1'b1;
    step();
    idle();
    check("restore_free_count", 32'(free_count), 32);
    for (int k = 0; k < A / 4; k++) begin
      set_lane(0, 4*k, 4*k+1, 0, 0);
      set_lane(1, 4*k+2, 4*k+3, 0, 0);
      eval_cycle();
      check("ident_a", 32'(rn_phy_rs1[0]), 32'(4*k));
      check("ident_b", 32'(rn_phy_rs2[0]), 32'(4*k+1));
      check("ident_c", 32'(rn_phy_rs1[1]), 32'(4*k+2));
      check("ident_d", 32'(rn_phy_rs2[1]), 32'(4*k+3));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
